// File: rtl/adder_pkg.sv
// Shared constants, result type and helper functions for the pipelined adder family.
package adder_pkg;

    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_STAGES = 4;

    typedef struct packed {
        logic [DEFAULT_WIDTH-1:0] sum;
        logic                     cout;
        logic                     ovf;
    } add_result_t;

    function automatic bit stages_divide_width(input int width, input int stages);
        return (stages > 32'sd0) && (width > 32'sd0) && ((width % stages) == 32'sd0);
    endfunction

    // Single full-adder cell: returns {carry_out, sum_bit}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational ripple-carry slice of CHUNK full-adder cells; also exposes the
// carry into its top bit so the last slice can derive signed overflow.
module adder_chunk
    import adder_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    // Ripple the carry through the slice, remembering the carry into the top bit.
    always_comb begin
        logic       c_v;
        logic [1:0] fa_v;
        c_v      = ci;
        fa_v     = 2'b00;
        s        = {CHUNK{1'b0}};
        c_msb_in = 1'b0;
        for (int i = 0; i < CHUNK; i++) begin
            c_msb_in = c_v;
            fa_v     = full_add(a[i], b[i], c_v);
            s[i]     = fa_v[0];
            c_v      = fa_v[1];
        end
        co = c_v;
    end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor: one CHUNK-bit ripple slice per stage,
// valid/ready handshake with a global stall that freezes every stage.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CHUNK = WIDTH / STAGES;
    localparam int OPS   = (STAGES > 1) ? STAGES - 1 : 1;
    localparam logic [WIDTH-1:0] CMASK = WIDTH'({CHUNK{1'b1}});

    if (!stages_divide_width(WIDTH, STAGES)) begin : g_cfg_err
        $error("pipelined_adder: WIDTH must be a multiple of STAGES");
    end

    // Per-stage source operands (stage 0 from the ports, others from the previous register)
    logic [WIDTH-1:0]  a_src_s    [STAGES];
    logic [WIDTH-1:0]  b_src_s    [STAGES];
    logic [WIDTH-1:0]  s_src_s    [STAGES];
    logic [WIDTH-1:0]  s_next_s   [STAGES];
    logic [CHUNK-1:0]  chunk_s    [STAGES];
    logic [STAGES-1:0] v_src_s;
    logic [STAGES-1:0] c_src_s;
    logic [STAGES-1:0] co_s;
    logic [STAGES-1:0] cmsb_s;

    logic [WIDTH-1:0]  a_r [OPS];
    logic [WIDTH-1:0]  b_r [OPS];
    logic [WIDTH-1:0]  s_r [STAGES];
    logic [STAGES-1:0] v_r;
    logic [STAGES-1:0] c_r;
    logic              ovf_r;
    logic              stall_s;

    assign stall_s   = v_r[STAGES-1] & ~out_ready;
    assign in_ready  = ~stall_s;
    assign out_valid = v_r[STAGES-1];
    assign sum       = s_r[STAGES-1];
    assign cout      = c_r[STAGES-1];
    assign ovf       = ovf_r;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_entry
            // Subtraction is a + ~b + ~cin, so borrow-in inverts into the carry chain.
            assign a_src_s[k] = a;
            assign b_src_s[k] = sub ? ~b : b;
            assign c_src_s[k] = sub ? ~cin : cin;
            assign s_src_s[k] = {WIDTH{1'b0}};
            assign v_src_s[k] = in_valid;
        end else begin : g_inner
            assign a_src_s[k] = a_r[k-1];
            assign b_src_s[k] = b_r[k-1];
            assign c_src_s[k] = c_r[k-1];
            assign s_src_s[k] = s_r[k-1];
            assign v_src_s[k] = v_r[k-1];
        end

        adder_chunk #(
            .CHUNK(CHUNK)
        ) u_chunk (
            .a       (a_src_s[k][k*CHUNK +: CHUNK]),
            .b       (b_src_s[k][k*CHUNK +: CHUNK]),
            .ci      (c_src_s[k]),
            .s       (chunk_s[k]),
            .co      (co_s[k]),
            .c_msb_in(cmsb_s[k])
        );

        assign s_next_s[k] = (s_src_s[k] & ~(CMASK << (k*CHUNK)))
                           | (WIDTH'(chunk_s[k]) << (k*CHUNK));
    end

    // Pipeline advance: all stages move together unless the output beat is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_r   <= {STAGES{1'b0}};
            c_r   <= {STAGES{1'b0}};
            ovf_r <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                s_r[k] <= {WIDTH{1'b0}};
            end
            for (int k = 0; k < OPS; k++) begin
                a_r[k] <= {WIDTH{1'b0}};
                b_r[k] <= {WIDTH{1'b0}};
            end
        end else if (!stall_s) begin
            v_r   <= v_src_s;
            c_r   <= co_s;
            ovf_r <= co_s[STAGES-1] ^ cmsb_s[STAGES-1];
            for (int k = 0; k < STAGES; k++) begin
                s_r[k] <= s_next_s[k];
            end
            for (int k = 0; k < STAGES - 1; k++) begin
                a_r[k] <= a_src_s[k];
                b_r[k] <= b_src_s[k];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and streaming checks of pipelined_adder in the default, single-stage
// and eight-stage configurations.
module tb_pipelined_adder;
    import adder_pkg::*;

    logic        clk;
    logic        rst_n;

    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [15:0] a, b, sum;

    logic        in_valid8, in_ready8, cin8, sub8, out_valid8, cout8, ovf8;
    logic [7:0]  a8, b8, sum8;

    logic        in_valid32, in_ready32, cin32, sub32, out_valid32, cout32, ovf32;
    logic [31:0] a32, b32, sum32;

    int checks;
    int errors;

    pipelined_adder #(.WIDTH(16), .STAGES(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    pipelined_adder #(.WIDTH(8), .STAGES(1)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(out_valid8),
        .out_ready(1'b1), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    pipelined_adder #(.WIDTH(32), .STAGES(8)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .cin(cin32), .sub(sub32), .out_valid(out_valid32),
        .out_ready(1'b1), .sum(sum32), .cout(cout32), .ovf(ovf32)
    );

    // Free-running 10-time-unit clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference result {sum, cout, ovf}; overflow derived from operand/result signs.
    function automatic logic [33:0] model(input logic [31:0] av, input logic [31:0] bv,
                                          input logic cv, input logic sv, input int w);
        logic [32:0] m, t;
        logic [31:0] be, s;
        logic        ce, co, ov;
        m  = (33'd1 << w) - 33'd1;
        be = (sv ? ~bv : bv) & m[31:0];
        ce = sv ? ~cv : cv;
        t  = {1'b0, av & m[31:0]} + {1'b0, be} + {32'd0, ce};
        s  = t[31:0] & m[31:0];
        co = t[w];
        ov = (av[w-1] == be[w-1]) && (s[w-1] != av[w-1]);
        return {s, co, ov};
    endfunction

    task automatic send_one(input string tag, input logic [15:0] av, input logic [15:0] bv,
                            input logic cv, input logic sv, input add_result_t exp);
        int cyc;
        cyc = 0;
        @(negedge clk);
        a = av; b = bv; cin = cv; sub = sv; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; a = 16'h0000; b = 16'h0000; cin = 1'b0; sub = 1'b0;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_lat"}, cyc, 4);
        chk({tag, "_res"}, {sum, cout, ovf}, exp);
        @(posedge clk);
        #1;
        chk({tag, "_drain"}, out_valid, 1'b0);
    endtask

    initial begin
        logic [33:0] q[$];
        logic [33:0] q8[$];
        logic [33:0] q32[$];
        logic [33:0] e;
        logic [17:0] prev_out;
        logic        prev_stall, first_seen, seen8, seen32;
        logic [15:0] ops_a [32];
        logic [15:0] ops_b [32];
        logic        ops_c [32];
        logic        ops_s [32];
        int          sent, recvd;
        logic [4:0]  j;

        checks = 0; errors = 0;
        clk = 1'b0; rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a = 16'h0; b = 16'h0; cin = 1'b0; sub = 1'b0;
        in_valid8 = 1'b0; a8 = 8'h0; b8 = 8'h0; cin8 = 1'b0; sub8 = 1'b0;
        in_valid32 = 1'b0; a32 = 32'h0; b32 = 32'h0; cin32 = 1'b0; sub32 = 1'b0;

        #1;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data", {sum, cout, ovf}, 18'h0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", in_ready, 1'b1);

        send_one("ffff_p1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, {16'h0000, 1'b1, 1'b0});
        send_one("7fff_p1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 1'b0, 1'b1});
        send_one("5_m_7",   16'h0005, 16'h0007, 1'b0, 1'b1, {16'hFFFE, 1'b0, 1'b0});
        send_one("8000_m1", 16'h8000, 16'h0001, 1'b0, 1'b1, {16'h7FFF, 1'b1, 1'b1});
        send_one("cin_add", 16'h1234, 16'h4321, 1'b1, 1'b0, {16'h5556, 1'b0, 1'b0});
        send_one("bin_sub", 16'h0010, 16'h0001, 1'b1, 1'b1, {16'h000E, 1'b1, 1'b0});

        // Back-to-back stream with random backpressure and junk operands while stalled.
        for (int i = 0; i < 32; i++) begin
            ops_a[i] = 16'($urandom());
            ops_b[i] = 16'($urandom());
            ops_c[i] = 1'($urandom());
            ops_s[i] = 1'($urandom());
        end
        sent = 0; recvd = 0; first_seen = 1'b0; prev_stall = 1'b0; prev_out = 18'h0;
        for (int cyc = 0; cyc < 400 && recvd < 32; cyc++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (sent < 32) begin
                in_valid = 1'b1;
                if (in_ready) begin
                    a = ops_a[sent]; b = ops_b[sent]; cin = ops_c[sent]; sub = ops_s[sent];
                end else begin
                    a = 16'($urandom()); b = 16'($urandom()); cin = 1'($urandom()); sub = 1'($urandom());
                end
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_data", {sum, cout, ovf}, prev_out);
            end
            if (first_seen && recvd < 32) begin
                chk("no_bubble", out_valid, 1'b1);
            end
            if (out_valid && out_ready) begin
                first_seen = 1'b1;
                chk("q_nonempty", (q.size() != 0), 1'b1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("stream", {16'h0, sum, cout, ovf}, e);
                end
                recvd++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model({16'h0, a}, {16'h0, b}, cin, sub, 16));
                sent++;
            end
            prev_stall = out_valid & ~out_ready;
            prev_out   = {sum, cout, ovf};
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stream_count", recvd, 32);
        chk("stream_sent", sent, 32);
        chk("stream_q_empty", q.size(), 0);

        // Asynchronous reset between clock edges while the pipeline is full.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 16'(i * 16'h0101); b = 16'h0011; cin = 1'b0; sub = 1'b0;
        end
        @(posedge clk);
        #2;
        chk("pre_rst_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", out_valid, 1'b0);
        chk("rst_mid_data", {sum, cout, ovf}, 18'h0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_idle", out_valid, 1'b0);
        end
        send_one("after_rst", 16'hA5A5, 16'h5A5A, 1'b1, 1'b0, {16'h0000, 1'b1, 1'b0});

        // Single-stage 8-bit sweep and eight-stage 32-bit stream, in parallel.
        seen8 = 1'b0; seen32 = 1'b0;
        for (int t = 0; t < 32768 + 16; t++) begin
            @(negedge clk);
            if (t < 32768) begin
                j  = 5'(t >> 8);
                a8 = 8'(t);
                b8 = 8'({3'b000, j} * 8'd8 + {5'b00000, j[2:0]});
                cin8 = 1'(t >> 13);
                sub8 = 1'(t >> 14);
                a32 = {a8, ~b8, b8 ^ 8'h5A, a8};
                b32 = {b8, a8, ~a8, b8};
                cin32 = cin8; sub32 = sub8;
                in_valid8 = 1'b1; in_valid32 = 1'b1;
            end else begin
                in_valid8 = 1'b0; in_valid32 = 1'b0;
            end
            #1;
            if (t == 0) begin
                chk("rdy8", in_ready8, 1'b1);
                chk("rdy32", in_ready32, 1'b1);
            end
            if (out_valid8) begin
                if (!seen8) begin
                    seen8 = 1'b1;
                    chk("lat8", t, 1);
                end
                chk("q8_nonempty", (q8.size() != 0), 1'b1);
                if (q8.size() != 0) begin
                    e = q8.pop_front();
                    chk("x8", {24'h0, sum8, cout8, ovf8}, e);
                end
            end
            if (out_valid32) begin
                if (!seen32) begin
                    seen32 = 1'b1;
                    chk("lat32", t, 8);
                end
                chk("q32_nonempty", (q32.size() != 0), 1'b1);
                if (q32.size() != 0) begin
                    e = q32.pop_front();
                    chk("x32", {sum32, cout32, ovf32}, e);
                end
            end
            if (t < 32768) begin
                q8.push_back(model({24'h0, a8}, {24'h0, b8}, cin8, sub8, 8));
                q32.push_back(model(a32, b32, cin32, sub32, 32));
            end
        end
        chk("seen8", seen8, 1'b1);
        chk("seen32", seen32, 1'b1);
        chk("q8_empty", q8.size(), 0);
        chk("q32_empty", q32.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
